// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/refill path.
// Holds the FSM encoding, line-address type and beat sizing.
package cache_pkg;

    localparam int LINE_BEATS = 4;
    localparam int BEAT_WIDTH = $clog2(LINE_BEATS);
    localparam int TAG_WIDTH  = 20;
    localparam int ADDR_WIDTH = 8;

    typedef logic [TAG_WIDTH+ADDR_WIDTH-1:0] cache_line_addr_t;

    typedef logic [2:0] refill_state_t;

    localparam refill_state_t S_IDLE    = 3'd0;
    localparam refill_state_t S_SELECT  = 3'd1;
    localparam refill_state_t S_WB_REQ  = 3'd2;
    localparam refill_state_t S_WB_WAIT = 3'd3;
    localparam refill_state_t S_MEM_REQ = 3'd4;
    localparam refill_state_t S_REFILL  = 3'd5;
    localparam refill_state_t S_COMMIT  = 3'd6;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/victim_select.sv
// Victim choice for a refill: lowest invalid way first, else the
// replacement unit's pick; flags whether that victim needs writeback.
module victim_select #(
    parameter int WAY_NUM   = 4,
    parameter int WAY_WIDTH = 2
) (
    input  logic [WAY_NUM-1:0]   way_valid,
    input  logic [WAY_NUM-1:0]   way_dirty,
    input  logic [WAY_WIDTH-1:0] repl_way,
    output logic [WAY_WIDTH-1:0] victim,
    output logic                 need_wb
);

    always_comb begin
        victim = repl_way;
        // Descending scan so the lowest invalid way wins.
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                victim = WAY_WIDTH'(i);
            end
        end
        need_wb = way_valid[victim] & way_dirty[victim];
    end

endmodule

// File: rtl/miss_refill_ctrl.sv
// Cache miss handler: picks a victim, writes it back if dirty,
// refills the line beat by beat and commits the new tag.
module miss_refill_ctrl #(
    parameter int DEPTH      = 256,
    parameter int WAY_NUM    = 4,
    parameter int WAY_WIDTH  = cache_pkg::idx_width(WAY_NUM),
    parameter int ADDR_WIDTH = cache_pkg::idx_width(DEPTH),
    parameter int TAG_WIDTH  = 20,
    parameter int LINE_BEATS = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BEAT_WIDTH = $clog2(LINE_BEATS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [ADDR_WIDTH-1:0]         miss_idx,
    input  logic [TAG_WIDTH-1:0]          miss_tag,
    input  logic [WAY_NUM-1:0]            way_valid,
    input  logic [WAY_NUM-1:0]            way_dirty,
    input  logic [WAY_NUM*TAG_WIDTH-1:0]  way_tag,
    output logic                          repl_req,
    output logic [ADDR_WIDTH-1:0]         repl_idx,
    input  logic [WAY_WIDTH-1:0]          repl_way,
    output logic                          repl_update_en,
    output logic [ADDR_WIDTH-1:0]         repl_update_idx,
    output logic [WAY_WIDTH-1:0]          repl_update_way,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [ADDR_WIDTH-1:0]         wb_idx,
    output logic [WAY_WIDTH-1:0]          wb_way,
    output logic [TAG_WIDTH-1:0]          wb_tag,
    input  logic                          wb_done,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [TAG_WIDTH+ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         mem_resp_data,
    output logic                          data_we,
    output logic [ADDR_WIDTH-1:0]         data_idx,
    output logic [WAY_WIDTH-1:0]          data_way,
    output logic [BEAT_WIDTH-1:0]         data_beat,
    output logic [DATA_WIDTH-1:0]         data_wdata,
    output logic                          tag_we,
    output logic [ADDR_WIDTH-1:0]         tag_idx,
    output logic [WAY_WIDTH-1:0]          tag_way,
    output logic [TAG_WIDTH-1:0]          tag_wtag,
    output logic                          refill_done
);

    import cache_pkg::*;

    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(LINE_BEATS - 1);

    refill_state_t state;
    refill_state_t state_nxt;

    logic [ADDR_WIDTH-1:0]        idx_q;
    logic [TAG_WIDTH-1:0]         tag_q;
    logic [WAY_WIDTH-1:0]         way_q;
    logic [WAY_NUM-1:0]           valid_q;
    logic [WAY_NUM-1:0]           dirty_q;
    logic [WAY_NUM*TAG_WIDTH-1:0] tags_q;
    logic [BEAT_WIDTH-1:0]        beat_q;

    logic [WAY_WIDTH-1:0] sel_way;
    logic                 sel_wb;

    logic in_idle;
    logic in_select;
    logic in_wb_req;
    logic in_wb_wait;
    logic in_mem_req;
    logic in_refill;
    logic in_commit;
    logic accept;
    logic last_beat;

    assign in_idle    = (state == S_IDLE);
    assign in_select  = (state == S_SELECT);
    assign in_wb_req  = (state == S_WB_REQ);
    assign in_wb_wait = (state == S_WB_WAIT);
    assign in_mem_req = (state == S_MEM_REQ);
    assign in_refill  = (state == S_REFILL);
    assign in_commit  = (state == S_COMMIT);

    assign accept    = in_idle & miss_valid;
    assign last_beat = in_refill & mem_resp_valid & (beat_q == LAST_BEAT);

    // Victim is decided from the snapshot taken when the miss arrived.
    victim_select #(
        .WAY_NUM   (WAY_NUM),
        .WAY_WIDTH (WAY_WIDTH)
    ) u_victim_select (
        .way_valid (valid_q),
        .way_dirty (dirty_q),
        .repl_way  (repl_way),
        .victim    (sel_way),
        .need_wb   (sel_wb)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (miss_valid)     state_nxt = S_SELECT;
            S_SELECT:  state_nxt = sel_wb ? S_WB_REQ : S_MEM_REQ;
            S_WB_REQ:  if (wb_ready)       state_nxt = S_WB_WAIT;
            S_WB_WAIT: if (wb_done)        state_nxt = S_MEM_REQ;
            S_MEM_REQ: if (mem_req_ready)  state_nxt = S_REFILL;
            S_REFILL:  if (last_beat)      state_nxt = S_COMMIT;
            S_COMMIT:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            tags_q  <= '0;
            beat_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= miss_idx;
                tag_q   <= miss_tag;
                valid_q <= way_valid;
                dirty_q <= way_dirty;
                tags_q  <= way_tag;
            end
            if (in_select) begin
                way_q <= sel_way;
            end
            if (in_mem_req && mem_req_ready) begin
                beat_q <= '0;
            end else if (in_refill && mem_resp_valid) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign miss_ready = in_idle;
    assign repl_req   = accept;
    assign repl_idx   = miss_idx;

    assign wb_valid = in_wb_req;
    assign wb_idx   = idx_q;
    assign wb_way   = way_q;
    assign wb_tag   = tags_q[int'(way_q)*TAG_WIDTH +: TAG_WIDTH];

    assign mem_req_valid = in_mem_req;
    assign mem_req_addr  = {tag_q, idx_q};

    assign data_we    = in_refill & mem_resp_valid;
    assign data_idx   = idx_q;
    assign data_way   = way_q;
    assign data_beat  = beat_q;
    assign data_wdata = mem_resp_data;

    assign tag_we   = in_commit;
    assign tag_idx  = idx_q;
    assign tag_way  = way_q;
    assign tag_wtag = tag_q;

    assign repl_update_en  = in_commit;
    assign repl_update_idx = idx_q;
    assign repl_update_way = way_q;
    assign refill_done     = in_commit;

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Directed bench for miss_refill_ctrl: clean/invalid/dirty misses,
// gapped refill beats, reset abort and back-to-back miss holding.
module tb_miss_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic        miss_ready;
    logic [7:0]  miss_idx;
    logic [19:0] miss_tag;
    logic [3:0]  way_valid;
    logic [3:0]  way_dirty;
    logic [79:0] way_tag;
    logic        repl_req;
    logic [7:0]  repl_idx;
    logic [1:0]  repl_way;
    logic        repl_update_en;
    logic [7:0]  repl_update_idx;
    logic [1:0]  repl_update_way;
    logic        wb_valid;
    logic        wb_ready;
    logic [7:0]  wb_idx;
    logic [1:0]  wb_way;
    logic [19:0] wb_tag;
    logic        wb_done;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [27:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        data_we;
    logic [7:0]  data_idx;
    logic [1:0]  data_way;
    logic [1:0]  data_beat;
    logic [63:0] data_wdata;
    logic        tag_we;
    logic [7:0]  tag_idx;
    logic [1:0]  tag_way;
    logic [19:0] tag_wtag;
    logic        refill_done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [79:0] WAY_TAGS =
        {20'hDDDD4, 20'hCCCC3, 20'hBBBB2, 20'hAAAA1};

    always #5 clk = ~clk;

    miss_refill_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .miss_valid      (miss_valid),
        .miss_ready      (miss_ready),
        .miss_idx        (miss_idx),
        .miss_tag        (miss_tag),
        .way_valid       (way_valid),
        .way_dirty       (way_dirty),
        .way_tag         (way_tag),
        .repl_req        (repl_req),
        .repl_idx        (repl_idx),
        .repl_way        (repl_way),
        .repl_update_en  (repl_update_en),
        .repl_update_idx (repl_update_idx),
        .repl_update_way (repl_update_way),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_idx          (wb_idx),
        .wb_way          (wb_way),
        .wb_tag          (wb_tag),
        .wb_done         (wb_done),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .data_we         (data_we),
        .data_idx        (data_idx),
        .data_way        (data_way),
        .data_beat       (data_beat),
        .data_wdata      (data_wdata),
        .tag_we          (tag_we),
        .tag_idx         (tag_idx),
        .tag_way         (tag_way),
        .tag_wtag        (tag_wtag),
        .refill_done     (refill_done)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full miss from IDLE back to IDLE; expected victim and
    // writeback decision are supplied by the caller.
    task automatic do_miss(
        input logic [7:0]  idx,
        input logic [19:0] tag,
        input logic [3:0]  vv,
        input logic [3:0]  dd,
        input logic [1:0]  rw,
        input logic [1:0]  exp_way,
        input logic        exp_wb,
        input logic [19:0] exp_wb_tag,
        input int          rdy_dly,
        input int          done_dly,
        input logic [15:0] pat,
        input int          pat_len,
        input logic        hold,
        input int          abort_at
    );
        int k;
        miss_valid = 1'b1;
        miss_idx   = idx;
        miss_tag   = tag;
        way_valid  = vv;
        way_dirty  = dd;
        way_tag    = WAY_TAGS;
        #1;
        check("accept_ready", miss_ready, 1'b1);
        check("accept_repl_req", repl_req, 1'b1);
        check("accept_repl_idx", repl_idx, idx);
        tick;
        if (!hold) begin
            miss_valid = 1'b0;
            miss_idx   = ~idx;
            miss_tag   = ~tag;
            way_valid  = 4'hF;
            way_dirty  = 4'hF;
            way_tag    = '0;
        end
        repl_way = rw;
        #1;
        check("select_ready", miss_ready, 1'b0);
        check("select_repl_req", repl_req, 1'b0);
        tick;
        repl_way = ~rw;
        if (exp_wb) begin
            for (int i = 0; i < rdy_dly; i++) begin
                #1;
                check("wb_valid_hold", wb_valid, 1'b1);
                check("wb_no_mem", mem_req_valid, 1'b0);
                tick;
            end
            wb_ready = 1'b1;
            #1;
            check("wb_valid", wb_valid, 1'b1);
            check("wb_way", wb_way, exp_way);
            check("wb_idx", wb_idx, idx);
            check("wb_tag", wb_tag, exp_wb_tag);
            tick;
            wb_ready = 1'b0;
            for (int i = 0; i < done_dly; i++) begin
                #1;
                check("wbwait_no_mem", mem_req_valid, 1'b0);
                check("wbwait_no_wb", wb_valid, 1'b0);
                tick;
            end
            wb_done = 1'b1;
            #1;
            check("wbdone_no_mem", mem_req_valid, 1'b0);
            tick;
            wb_done = 1'b0;
        end
        #1;
        check("memreq_valid", mem_req_valid, 1'b1);
        check("memreq_no_wb", wb_valid, 1'b0);
        check("memreq_addr", mem_req_addr, {tag, idx});
        check("memreq_ready_low", miss_ready, hold ? 1'b0 : 1'b0);
        tick;
        mem_req_ready = 1'b1;
        #1;
        check("memreq_valid2", mem_req_valid, 1'b1);
        tick;
        mem_req_ready = 1'b0;
        k = 0;
        for (int j = 0; j < pat_len; j++) begin
            mem_resp_valid = pat[j];
            mem_resp_data  = {32'hC0DE0000 | 32'(idx), 32'(k * 16 + j)};
            if (pat[j] && k == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_no_tag", tag_we, 1'b0);
                tick;
                rst = 1'b0;
                mem_resp_valid = 1'b0;
                #1;
                check("abort_idle", miss_ready, 1'b1);
                check("abort_tag_we", tag_we, 1'b0);
                check("abort_done", refill_done, 1'b0);
                check("abort_data_we", data_we, 1'b0);
                tick;
                check("abort_done2", refill_done, 1'b0);
                return;
            end
            #1;
            check("refill_we", data_we, pat[j]);
            check("refill_no_tag", tag_we, 1'b0);
            check("refill_busy", miss_ready, 1'b0);
            if (pat[j]) begin
                check("refill_beat", data_beat, k[1:0]);
                check("refill_way", data_way, exp_way);
                check("refill_idx", data_idx, idx);
                check("refill_data", data_wdata,
                      {32'hC0DE0000 | 32'(idx), 32'(k * 16 + j)});
                k++;
            end
            tick;
        end
        mem_resp_valid = 1'b0;
        #1;
        check("commit_tag_we", tag_we, 1'b1);
        check("commit_tag_idx", tag_idx, idx);
        check("commit_tag_way", tag_way, exp_way);
        check("commit_tag", tag_wtag, tag);
        check("commit_upd_en", repl_update_en, 1'b1);
        check("commit_upd_idx", repl_update_idx, idx);
        check("commit_upd_way", repl_update_way, exp_way);
        check("commit_done", refill_done, 1'b1);
        check("commit_busy", miss_ready, 1'b0);
        check("commit_data_we", data_we, 1'b0);
        tick;
        check("post_ready", miss_ready, 1'b1);
        check("post_done", refill_done, 1'b0);
        check("post_tag_we", tag_we, 1'b0);
        check("post_repl_req", repl_req, hold);
    endtask

    initial begin
        rst            = 1'b1;
        miss_valid     = 1'b0;
        miss_idx       = '0;
        miss_tag       = '0;
        way_valid      = '0;
        way_dirty      = '0;
        way_tag        = '0;
        repl_way       = '0;
        wb_ready       = 1'b0;
        wb_done        = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick;
        tick;
        check("rst_ready", miss_ready, 1'b1);
        check("rst_repl_req", repl_req, 1'b0);
        check("rst_upd_en", repl_update_en, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_data_we", data_we, 1'b0);
        check("rst_tag_we", tag_we, 1'b0);
        check("rst_done", refill_done, 1'b0);
        check("rst_beat", data_beat, 2'd0);
        check("rst_addr", mem_req_addr, 28'd0);
        rst = 1'b0;
        tick;

        // Clean miss, all valid, replacement picks way 2.
        do_miss(8'h12, 20'h12345, 4'hF, 4'h0, 2'd2, 2'd2, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b0, -1);
        // Invalid way 2 overrides repl_way.
        do_miss(8'h34, 20'hABCDE, 4'b1011, 4'h0, 2'd0, 2'd2, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b0, -1);
        // Dirty victim way 1 with slow writeback handshake.
        do_miss(8'h56, 20'h0F0F0, 4'hF, 4'b0010, 2'd1, 2'd1, 1'b1,
                20'hBBBB2, 3, 4, 16'h000F, 4, 1'b0, -1);
        // Dirty but invalid way 0: chosen, no writeback.
        do_miss(8'h60, 20'h11111, 4'b1110, 4'b0001, 2'd3, 2'd0, 1'b0,
                20'h0, 0, 0, 16'h000F, 4, 1'b0, -1);
        // Gapped beats 1,0,0,1,1,0,1.
        do_miss(8'h78, 20'h77777, 4'hF, 4'h0, 2'd3, 2'd3, 1'b0, 20'h0,
                0, 0, 16'h0059, 7, 1'b0, -1);
        // Reset during beat 2, then a fresh miss.
        do_miss(8'h9A, 20'h9999A, 4'hF, 4'h0, 2'd0, 2'd0, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b0, 2);
        do_miss(8'h9B, 20'h9999B, 4'b0111, 4'h0, 2'd1, 2'd3, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b0, -1);
        // Miss held across a busy refill; second accepted after done.
        do_miss(8'hBC, 20'hBCBCB, 4'hF, 4'h0, 2'd1, 2'd1, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b1, -1);
        do_miss(8'hBC, 20'hBCBCB, 4'hF, 4'h0, 2'd3, 2'd3, 1'b0, 20'h0,
                0, 0, 16'h000F, 4, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
